// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: operation codes, control states and
// a small opcode classification helper.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_MUL  = 4'd11
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic op_is_mul(input alu_op_t op);
        return (op == ALU_MUL);
    endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Iterative unsigned shift-add multiplier: one partial-product step per cycle,
// WIDTH steps in total, with a one-cycle done pulse when the product is final.
module seq_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // Low half of acc holds the remaining multiplier bits; high half accumulates.
    function automatic logic [2*WIDTH-1:0] mul_step(
        input logic [2*WIDTH-1:0] acc,
        input logic [WIDTH-1:0]   mc
    );
        logic [WIDTH:0] part;
        part = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mc} : {(WIDTH+1){1'b0}});
        return {part, acc[WIDTH-1:1]};
    endfunction

    // Next-state: the first step is folded into the load so WIDTH steps end after WIDTH edges.
    always_comb begin
        mcand_d = mcand_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        if (start && !busy_q) begin
            mcand_d = a;
            acc_d   = mul_step({{WIDTH{1'b0}}, b}, a);
            cnt_d   = CW'(1);
            busy_d  = 1'b1;
        end else if (busy_q) begin
            acc_d = mul_step(acc_q, mcand_q);
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end else begin
                busy_d = 1'b1;
            end
        end else begin
            busy_d = 1'b0;
        end
    end

    // State registers; reset aborts any multiply in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mcand_q <= {WIDTH{1'b0}};
            acc_q   <= {(2*WIDTH){1'b0}};
            cnt_q   <= {CW{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = acc_q;

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with valid/ready handshakes: single-cycle arithmetic, logic,
// compare and shift ops, plus a multi-cycle unsigned multiply.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_hi,
    output logic             zero,
    output logic             carry,
    output logic             overflow
);

    state_t             state_q;
    logic [WIDTH-1:0]   y_q, y_hi_q;
    logic               zero_q, carry_q, ovf_q;

    alu_op_t            op_s;
    logic               accept_s, mul_start_s;
    logic [WIDTH:0]     sum_s, diff_s;
    logic [WIDTH-1:0]   res_s;
    logic               carry_s, ovf_s, slt_s, sltu_s;
    logic [SHW-1:0]     shamt_s;
    logic               mul_busy_s, mul_done_s;
    logic [2*WIDTH-1:0] mul_product_s;

    assign op_s        = alu_op_t'(op);
    assign in_ready    = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign accept_s    = in_valid && in_ready;
    assign mul_start_s = accept_s && op_is_mul(op_s);

    // Single-cycle result and flags; undefined codes fall through to zero.
    always_comb begin
        sum_s   = {1'b0, a} + {1'b0, b};
        diff_s  = {1'b0, a} - {1'b0, b};
        slt_s   = ($signed(a) < $signed(b));
        sltu_s  = (a < b);
        shamt_s = b[SHW-1:0];
        res_s   = {WIDTH{1'b0}};
        carry_s = 1'b0;
        ovf_s   = 1'b0;
        case (op_s)
            ALU_ADD: begin
                res_s   = sum_s[WIDTH-1:0];
                carry_s = sum_s[WIDTH];
                ovf_s   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUB: begin
                res_s   = diff_s[WIDTH-1:0];
                carry_s = diff_s[WIDTH];
                ovf_s   = (a[WIDTH-1] != b[WIDTH-1]) && (diff_s[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_AND:  res_s = a & b;
            ALU_OR:   res_s = a | b;
            ALU_XOR:  res_s = a ^ b;
            ALU_NOR:  res_s = ~(a | b);
            ALU_SLT:  res_s = {{(WIDTH-1){1'b0}}, slt_s};
            ALU_SLTU: res_s = {{(WIDTH-1){1'b0}}, sltu_s};
            ALU_SLL:  res_s = a << shamt_s;
            ALU_SRL:  res_s = a >> shamt_s;
            ALU_SRA:  res_s = $unsigned($signed(a) >>> shamt_s);
            ALU_MUL:  res_s = {WIDTH{1'b0}};
            default:  res_s = {WIDTH{1'b0}};
        endcase
    end

    seq_multiplier #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (mul_start_s),
        .a       (a),
        .b       (b),
        .busy    (mul_busy_s),
        .done    (mul_done_s),
        .product (mul_product_s)
    );

    // Control FSM with registered result/flags; outputs hold while waiting for out_ready.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            y_q     <= {WIDTH{1'b0}};
            y_hi_q  <= {WIDTH{1'b0}};
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (accept_s) begin
                        if (op_is_mul(op_s)) begin
                            state_q <= ST_BUSY;
                        end else begin
                            state_q <= ST_DONE;
                            y_q     <= res_s;
                            y_hi_q  <= {WIDTH{1'b0}};
                            zero_q  <= (res_s == {WIDTH{1'b0}});
                            carry_q <= carry_s;
                            ovf_q   <= ovf_s;
                        end
                    end else if ((state_q == ST_DONE) && out_ready) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= state_q;
                    end
                end
                ST_BUSY: begin
                    if (mul_done_s && !mul_busy_s) begin
                        state_q <= ST_DONE;
                        y_q     <= mul_product_s[WIDTH-1:0];
                        y_hi_q  <= mul_product_s[2*WIDTH-1:WIDTH];
                        zero_q  <= (mul_product_s == {(2*WIDTH){1'b0}});
                        carry_q <= 1'b0;
                        ovf_q   <= 1'b0;
                    end else begin
                        state_q <= ST_BUSY;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign out_valid = (state_q == ST_DONE);
    assign y         = y_q;
    assign y_hi      = y_hi_q;
    assign zero      = zero_q;
    assign carry     = carry_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu at WIDTH=8 and WIDTH=32: expected results are
// queued when stimulus is driven and checked when each result is consumed.
module tb_seq_alu;

    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLT = 4'd6, OP_SLTU = 4'd7, OP_SRA = 4'd10, OP_MUL = 4'd11;

    typedef struct packed {
        logic [63:0] y;
        logic [63:0] yh;
        logic        z;
        logic        c;
        logic        v;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    logic       in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b1;
    logic [3:0] op8 = 4'd0;
    logic [7:0] a8 = 8'd0, b8 = 8'd0, y8, y_hi8;
    logic       zero8, carry8, ovf8;

    logic        in_valid32 = 1'b0, in_ready32, out_valid32, out_ready32 = 1'b1;
    logic [3:0]  op32 = 4'd0;
    logic [31:0] a32 = 32'd0, b32 = 32'd0, y32, y_hi32;
    logic        zero32, carry32, ovf32;

    exp_t sb8[$];
    exp_t sb32[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .op(op8), .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8),
        .y(y8), .y_hi(y_hi8), .zero(zero8), .carry(carry8), .overflow(ovf8)
    );

    seq_alu #(.WIDTH(32)) dut32 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid32), .in_ready(in_ready32),
        .op(op32), .a(a32), .b(b32), .out_valid(out_valid32), .out_ready(out_ready32),
        .y(y32), .y_hi(y_hi32), .zero(zero32), .carry(carry32), .overflow(ovf32)
    );

    function automatic exp_t mk(input logic [63:0] y, input logic [63:0] yh,
                                input logic z, input logic c, input logic v);
        exp_t e;
        e.y = y; e.yh = yh; e.z = z; e.c = c; e.v = v;
        return e;
    endfunction

    // Reference model on 64-bit arithmetic, masked to w bits (w = 8 or 32).
    function automatic exp_t model(input int w, input logic [3:0] o,
                                   input logic [63:0] ai, input logic [63:0] bi);
        exp_t        e;
        logic [63:0] m, a, b, p;
        longint      sa, sb;
        int          sh;
        m  = (64'd1 << w) - 64'd1;
        a  = ai & m;
        b  = bi & m;
        e  = '0;
        sh = int'(b & 64'(w - 1));
        sa = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
        sb = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
        case (o)
            4'd0: begin
                p = a + b; e.y = p & m; e.c = p[w];
                e.v = (a[w-1] == b[w-1]) && (e.y[w-1] != a[w-1]);
            end
            4'd1: begin
                e.y = (a - b) & m; e.c = (a < b);
                e.v = (a[w-1] != b[w-1]) && (e.y[w-1] != a[w-1]);
            end
            4'd2:  e.y = a & b;
            4'd3:  e.y = a | b;
            4'd4:  e.y = a ^ b;
            4'd5:  e.y = ~(a | b) & m;
            4'd6:  e.y = (sa < sb) ? 64'd1 : 64'd0;
            4'd7:  e.y = (a < b) ? 64'd1 : 64'd0;
            4'd8:  e.y = (a << sh) & m;
            4'd9:  e.y = a >> sh;
            4'd10: e.y = (a >> sh) | (a[w-1] ? (m & ~(m >> sh)) : 64'd0);
            4'd11: begin p = a * b; e.y = p & m; e.yh = (p >> w) & m; end
            default: e.y = 64'd0;
        endcase
        e.z = (e.y == 64'd0) && (e.yh == 64'd0);
        return e;
    endfunction

    // Scoreboard check for the 8-bit instance on every consumed result.
    always @(negedge clk) begin
        if (reset_n && out_valid8 && out_ready8) begin
            n_vec++;
            if (sb8.size() == 0) begin
                n_err++;
                $display("FAIL sb8_unexpected: got y=%h y_hi=%h with no result queued", y8, y_hi8);
            end else begin
                exp_t e;
                e = sb8.pop_front();
                if ({56'd0, y8} !== e.y || {56'd0, y_hi8} !== e.yh || zero8 !== e.z ||
                    carry8 !== e.c || ovf8 !== e.v) begin
                    n_err++;
                    $display("FAIL sb8_result: got y=%h y_hi=%h z=%b c=%b v=%b, exp y=%h y_hi=%h z=%b c=%b v=%b",
                             y8, y_hi8, zero8, carry8, ovf8, e.y[7:0], e.yh[7:0], e.z, e.c, e.v);
                end
            end
        end
    end

    // Scoreboard check for the 32-bit instance.
    always @(negedge clk) begin
        if (reset_n && out_valid32 && out_ready32) begin
            n_vec++;
            if (sb32.size() == 0) begin
                n_err++;
                $display("FAIL sb32_unexpected: got y=%h y_hi=%h with no result queued", y32, y_hi32);
            end else begin
                exp_t e;
                e = sb32.pop_front();
                if ({32'd0, y32} !== e.y || {32'd0, y_hi32} !== e.yh || zero32 !== e.z ||
                    carry32 !== e.c || ovf32 !== e.v) begin
                    n_err++;
                    $display("FAIL sb32_result: got y=%h y_hi=%h z=%b c=%b v=%b, exp y=%h y_hi=%h z=%b c=%b v=%b",
                             y32, y_hi32, zero32, carry32, ovf32, e.y[31:0], e.yh[31:0], e.z, e.c, e.v);
                end
            end
        end
    end

    // Drive one op, wait for acceptance, return cycles until out_valid (-1 on timeout).
    task automatic send8(input logic [3:0] o, input logic [7:0] xa, input logic [7:0] xb, output int lat);
        int w;
        op8 = o; a8 = xa; b8 = xb; in_valid8 = 1'b1;
        #1;
        w = 0;
        while (in_ready8 !== 1'b1 && w < 50) begin @(posedge clk); #1; w++; end
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        lat = 1;
        while (out_valid8 !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
        if (out_valid8 !== 1'b1) lat = -1;
    endtask

    task automatic send32(input logic [3:0] o, input logic [31:0] xa, input logic [31:0] xb, output int lat);
        int w;
        op32 = o; a32 = xa; b32 = xb; in_valid32 = 1'b1;
        #1;
        w = 0;
        while (in_ready32 !== 1'b1 && w < 50) begin @(posedge clk); #1; w++; end
        @(posedge clk); #1;
        in_valid32 = 1'b0;
        lat = 1;
        while (out_valid32 !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
        if (out_valid32 !== 1'b1) lat = -1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0 || y8 !== 8'd0 || y_hi8 !== 8'd0 ||
            zero8 !== 1'b0 || carry8 !== 1'b0 || ovf8 !== 1'b0) begin
            n_err++;
            $display("FAIL reset8: got rdy=%b vld=%b y=%h yh=%h z=%b c=%b v=%b, exp 1 0 00 00 0 0 0",
                     in_ready8, out_valid8, y8, y_hi8, zero8, carry8, ovf8);
        end
        n_vec++;
        if (in_ready32 !== 1'b1 || out_valid32 !== 1'b0 || y32 !== 32'd0 || y_hi32 !== 32'd0 ||
            zero32 !== 1'b0 || carry32 !== 1'b0 || ovf32 !== 1'b0) begin
            n_err++;
            $display("FAIL reset32: got rdy=%b vld=%b y=%h yh=%h z=%b c=%b v=%b, exp 1 0 0 0 0 0 0",
                     in_ready32, out_valid32, y32, y_hi32, zero32, carry32, ovf32);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_arith();
        logic [3:0] ops [7];
        logic [7:0] as  [7];
        logic [7:0] bs  [7];
        exp_t       es  [7];
        int         lat;
        ops = '{OP_ADD, OP_ADD, OP_SUB, OP_SUB, OP_SLT, OP_SLTU, OP_SRA};
        as  = '{8'hFF, 8'h7F, 8'h05, 8'h80, 8'h80, 8'h80, 8'h90};
        bs  = '{8'h01, 8'h01, 8'h07, 8'h01, 8'h01, 8'h01, 8'h02};
        es  = '{mk(64'h00, 64'h0, 1'b1, 1'b1, 1'b0), mk(64'h80, 64'h0, 1'b0, 1'b0, 1'b1),
                mk(64'hFE, 64'h0, 1'b0, 1'b1, 1'b0), mk(64'h7F, 64'h0, 1'b0, 1'b0, 1'b1),
                mk(64'h01, 64'h0, 1'b0, 1'b0, 1'b0), mk(64'h00, 64'h0, 1'b1, 1'b0, 1'b0),
                mk(64'hE4, 64'h0, 1'b0, 1'b0, 1'b0)};
        out_ready8 = 1'b1;
        for (int i = 0; i < 7; i++) begin
            sb8.push_back(es[i]);
            send8(ops[i], as[i], bs[i], lat);
            n_vec++;
            if (lat !== 1) begin
                n_err++;
                $display("FAIL arith_latency[%0d]: got %0d cycles, exp 1", i, lat);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [3:0] o;
        logic [7:0] xa, xb;
        int         lat;
        out_ready8 = 1'b1;
        for (int i = 0; i < 30; i++) begin
            o  = 4'($urandom_range(0, 12));
            xa = 8'($urandom);
            xb = 8'($urandom);
            sb8.push_back(model(8, o, {56'd0, xa}, {56'd0, xb}));
            send8(o, xa, xb, lat);
            n_vec++;
            if (lat !== ((o == OP_MUL) ? 9 : 1)) begin
                n_err++;
                $display("FAIL b2b_latency[%0d] op=%0d: got %0d cycles, exp %0d", i, o, lat, (o == OP_MUL) ? 9 : 1);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_mul();
        int lat;
        out_ready8 = 1'b1;
        sb8.push_back(mk(64'h01, 64'hFE, 1'b0, 1'b0, 1'b0));
        op8 = OP_MUL; a8 = 8'hFF; b8 = 8'hFF; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        lat = 1;
        while (out_valid8 !== 1'b1 && lat < 100) begin
            n_vec++;
            if (in_ready8 !== 1'b0) begin
                n_err++;
                $display("FAIL mul_busy_ready cycle %0d: got in_ready=%b, exp 0", lat, in_ready8);
            end
            if (lat == 3) begin
                in_valid8 = 1'b1; op8 = OP_ADD; a8 = 8'h01; b8 = 8'h01;
            end else begin
                in_valid8 = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        in_valid8 = 1'b0;
        n_vec++;
        if (lat !== 9) begin
            n_err++;
            $display("FAIL mul_latency: got %0d cycles, exp 9", lat);
        end
        @(posedge clk); #1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        int lat;
        out_ready8 = 1'b0;
        sb8.push_back(mk(64'h07, 64'h0, 1'b0, 1'b0, 1'b0));
        send8(OP_ADD, 8'd3, 8'd4, lat);
        n_vec++;
        if (lat !== 1) begin
            n_err++;
            $display("FAIL bp_latency: got %0d cycles, exp 1", lat);
        end
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (out_valid8 !== 1'b1 || in_ready8 !== 1'b0 || y8 !== 8'h07) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: got vld=%b rdy=%b y=%h, exp 1 0 07", i, out_valid8, in_ready8, y8);
            end
            @(posedge clk); #1;
        end
        sb8.push_back(mk(64'hFF, 64'h0, 1'b0, 1'b0, 1'b0));
        op8 = OP_XOR; a8 = 8'hF0; b8 = 8'h0F; in_valid8 = 1'b1; out_ready8 = 1'b1;
        #1;
        n_vec++;
        if (in_ready8 !== 1'b1) begin
            n_err++;
            $display("FAIL bp_same_cycle_ready: got %b, exp 1", in_ready8);
        end
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        n_vec++;
        if (out_valid8 !== 1'b1 || y8 !== 8'hFF) begin
            n_err++;
            $display("FAIL bp_next_result: got vld=%b y=%h, exp 1 ff", out_valid8, y8);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_mul();
        int lat;
        out_ready8 = 1'b1;
        op8 = OP_MUL; a8 = 8'h12; b8 = 8'h34; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        n_vec++;
        if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1 || y8 !== 8'd0 || y_hi8 !== 8'd0) begin
            n_err++;
            $display("FAIL reset_mid_mul: got vld=%b rdy=%b y=%h yh=%h, exp 0 1 00 00", out_valid8, in_ready8, y8, y_hi8);
        end
        #2;
        reset_n = 1'b1;
        @(posedge clk); #1;
        sb8.push_back(mk(64'h02, 64'h0, 1'b0, 1'b0, 1'b0));
        send8(OP_ADD, 8'd1, 8'd1, lat);
        n_vec++;
        if (lat !== 1) begin
            n_err++;
            $display("FAIL post_reset_latency: got %0d cycles, exp 1", lat);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_undefined();
        int lat;
        out_ready8 = 1'b1;
        sb8.push_back(mk(64'h00, 64'h0, 1'b1, 1'b0, 1'b0));
        send8(4'hF, 8'h55, 8'hAA, lat);
        n_vec++;
        if (lat !== 1) begin
            n_err++;
            $display("FAIL undef_latency: got %0d cycles, exp 1", lat);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_width32();
        int          lat;
        logic [3:0]  o;
        logic [31:0] xa, xb;
        out_ready32 = 1'b1;
        sb32.push_back(mk(64'h0, 64'h0, 1'b1, 1'b1, 1'b0));
        send32(OP_ADD, 32'hFFFF_FFFF, 32'h1, lat);
        n_vec++;
        if (lat !== 1) begin n_err++; $display("FAIL w32_add_latency: got %0d cycles, exp 1", lat); end
        sb32.push_back(mk(64'h8000_0000, 64'h0, 1'b0, 1'b0, 1'b1));
        send32(OP_ADD, 32'h7FFF_FFFF, 32'h1, lat);
        n_vec++;
        if (lat !== 1) begin n_err++; $display("FAIL w32_ovf_latency: got %0d cycles, exp 1", lat); end
        sb32.push_back(mk(64'hFFFF_FFFE, 64'h1, 1'b0, 1'b0, 1'b0));
        send32(OP_MUL, 32'hFFFF_FFFF, 32'h2, lat);
        n_vec++;
        if (lat !== 33) begin n_err++; $display("FAIL w32_mul_latency: got %0d cycles, exp 33", lat); end
        for (int i = 0; i < 10; i++) begin
            o  = 4'($urandom_range(0, 11));
            xa = $urandom;
            xb = $urandom;
            sb32.push_back(model(32, o, {32'd0, xa}, {32'd0, xb}));
            send32(o, xa, xb, lat);
            n_vec++;
            if (lat !== ((o == OP_MUL) ? 33 : 1)) begin
                n_err++;
                $display("FAIL w32_rand_latency[%0d] op=%0d: got %0d cycles, exp %0d", i, o, lat, (o == OP_MUL) ? 33 : 1);
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_arith();
        test_back_to_back();
        test_mul();
        test_backpressure();
        test_reset_mid_mul();
        test_undefined();
        test_width32();
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (sb8.size() != 0 || sb32.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: got %0d/%0d results outstanding, exp 0/0", sb8.size(), sb32.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
